mem_timing_backend: RTL

- Memory endpoint directly downstream of the three-client memory arbiter. It consumes the arbiter's mem_req/mem_we/mem_addr/mem_wdata stream and returns mem_valid/mem_rdata.
- Backs a single-port 64-bit word array and models DRAM-like open-row timing: row hit costs HIT_LAT cycles, row miss costs MISS_LAT cycles.
- Every request (read or write) gets exactly one response, in issue order. The arbiter's ticket FIFO depends on this for routing.

---
 rtl/mem_timing_backend.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_timing_backend.sv
// Open-row timed memory endpoint behind the three-client arbiter: queues requests and answers each one in order.
// Define MEM_STATS_EN to build the row hit/miss counters; without it stat_hits/stat_misses read as 0.
module mem_timing_backend #(
    parameter int ADDR_W   = 10,
    parameter int COL_W    = 4,
    parameter int QDEPTH   = 8,
    parameter int HIT_LAT  = 2,
    parameter int MISS_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic        mem_valid,
    output logic [63:0] mem_rdata,
    output logic        ovf_err,
    output logic        busy,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic        dbg_state
);

    // Handshake: the request side has no backpressure -- any edge with mem_req=1 offers one request,
    // which is queued or (queue full) dropped with ovf_err. mem_valid is a one-cycle pulse, one per
    // queued request, in issue order; mem_rdata is meaningful only with mem_valid and holds otherwise.

    localparam int ROW_W = ADDR_W - COL_W;
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int ENT_W = 1 + ADDR_W + 64;
    localparam logic [PTR_W:0] FULL     = (PTR_W + 1)'(QDEPTH);
    localparam logic [4:0]     HIT_CNT  = 5'(HIT_LAT - 1);
    localparam logic [4:0]     MISS_CNT = 5'(MISS_LAT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state, state_next;
    logic [ENT_W-1:0]   q_mem [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count, count_next;
    logic               push, pop, access, hit;
    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [63:0]        head_wdata;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_addr;
    logic [63:0]        acc_wdata;
    logic [4:0]         cnt, cnt_next;
    logic [ROW_W-1:0]   open_row;
    logic               row_open;
    logic [63:0]        array [2**ADDR_W];
    logic               unused_addr_bits;

    // Upper address bits alias onto the implemented array.
    assign unused_addr_bits = ^mem_addr[63:ADDR_W];

    assign {head_we, head_addr, head_wdata} = q_mem[rd_ptr];
    assign push      = mem_req && (count != FULL);
    assign hit       = row_open && (head_addr[ADDR_W-1:COL_W] == open_row);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 5'd0) begin
                    cnt_next = cnt - 5'd1;
                end else begin
                    access = 1'b1;
                    if (count != '0) pop = 1'b1;
                    else             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (pop) cnt_next = hit ? HIT_CNT : MISS_CNT;
        count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= {mem_we, mem_addr[ADDR_W-1:0], mem_wdata};
    end

    // A reset landing on the access edge must not disturb the array.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we) array[acc_addr] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            open_row  <= '0;
            row_open  <= 1'b0;
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            ovf_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            count     <= count_next;
            mem_valid <= access;
            busy      <= (count_next != '0) || (state_next == WAIT);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (mem_req && !push) ovf_err <= 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                acc_we    <= head_we;
                acc_addr  <= head_addr;
                acc_wdata <= head_wdata;
                open_row  <= head_addr[ADDR_W-1:COL_W];
                row_open  <= 1'b1;
            end
            if (access) mem_rdata <= acc_we ? acc_wdata : array[acc_addr];
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (pop) begin
            if (hit) hits_q   <= hits_q + 32'd1;
            else     misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
